// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential signed Qm.Q divider, c = a / b.
// Restoring radix-2 on magnitudes, one quotient bit per clock.
//
// Parameters:
//   Q  fractional bits of a, b and c
//   N  total word width, sign bit included
//
// Ports:
//   clk          rising-edge clock
//   rst_n        async active-low reset
//   a, b         dividend / divisor, sampled on accept
//   in_valid     operands present
//   in_ready     divider idle, can accept
//   c            quotient, held while out_valid
//   out_valid    result available
//   out_ready    consumer takes result
//   div_by_zero  b was zero (valid with out_valid)
//   overflow     quotient not representable (valid with out_valid)
//
// Build option QDIV_SATURATE_EN: saturate c on overflow and on
// divide-by-zero instead of wrapping / returning zero.

module qdiv_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic          sign;
  logic          dz;
  logic [N-1:0]  abs_b;
  logic [W-1:0]  dvd;
  logic [N:0]    rem;
  logic [W-1:0]  qm;
  logic [CW-1:0] cnt;

`ifdef QDIV_SATURATE_EN
  logic          a_neg;
`endif

  logic          accept;
  logic [N-1:0]  abs_a_in;
  logic [N-1:0]  abs_b_in;
  logic [N+1:0]  rem_sh;
  logic          ge;
  logic          ov_pos;
  logic          ov_neg;
  logic          ovf;
  logic [N-1:0]  wrap;
  logic [N-1:0]  res_c;
  logic          res_ov;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;

  // -MIN_NEG wraps to MIN_NEG, which read unsigned is 2^(N-1).
  assign abs_a_in = a[N-1] ? -a : a;
  assign abs_b_in = b[N-1] ? -b : b;

  // Remainder stays below |b|, so the shifted value
  // never needs more than N+1 bits; the extra top bit
  // keeps the compare exact.
  assign rem_sh = {rem, dvd[W-1]};
  assign ge     = rem_sh >= {2'b00, abs_b};

  // qm is compared at full width so bits above N count.
  assign ov_pos = qm > {{Q{1'b0}}, MAX_POS};
  assign ov_neg = qm > {{Q{1'b0}}, MIN_NEG};
  assign ovf    = sign ? ov_neg : ov_pos;

  // Low N bits of -qm equal the negation of qm's low N bits.
  assign wrap = sign ? -qm[N-1:0] : qm[N-1:0];

  always_comb begin
    res_c  = '0;
    res_ov = 1'b0;
    if (dz) begin
`ifdef QDIV_SATURATE_EN
      res_c = a_neg ? MIN_NEG : MAX_POS;
`else
      res_c = '0;
`endif
    end else begin
      res_ov = ovf;
`ifdef QDIV_SATURATE_EN
      if (ovf) res_c = sign ? MIN_NEG : MAX_POS;
      else     res_c = wrap;
`else
      res_c = wrap;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sign        <= 1'b0;
      dz          <= 1'b0;
      abs_b       <= '0;
      dvd         <= '0;
      rem         <= '0;
      qm          <= '0;
      cnt         <= '0;
      c           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef QDIV_SATURATE_EN
      a_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign  <= a[N-1] ^ b[N-1];
            abs_b <= abs_b_in;
            dvd   <= {abs_a_in, {Q{1'b0}}};
            rem   <= '0;
            qm    <= '0;
            cnt   <= CW'(W);
            dz    <= (b == '0);
`ifdef QDIV_SATURATE_EN
            a_neg <= a[N-1];
`endif
            state <= (b == '0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (ge) rem <= rem_sh[N:0] - {1'b0, abs_b};
          else    rem <= rem_sh[N:0];
          dvd <= {dvd[W-2:0], 1'b0};
          qm  <= {qm[W-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          c           <= res_c;
          div_by_zero <= dz;
          overflow    <= res_ov;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: random + directed checks of qdiv_seq
// against an arithmetic reference model.

module tb_qdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] c;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        div_by_zero;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_c;

  qdiv_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .c(c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input  logic [31:0] av,
                                input  logic [31:0] bv,
                                output logic [31:0] ce,
                                output logic        dze,
                                output logic        ove);
    longint sa, sb;
    longint unsigned ma, mb, qv;
    logic s;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    s   = av[31] ^ bv[31];
    dze = (bv == 32'h0);
    ove = 1'b0;
    ce  = 32'h0;
    if (dze) begin
`ifdef QDIV_SATURATE_EN
      ce = av[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
      return;
    end
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    qv  = (ma << 15) / mb;
    ove = s ? (qv > 64'h80000000) : (qv > 64'h7FFFFFFF);
    ce  = s ? 32'(64'd0 - qv) : 32'(qv);
`ifdef QDIV_SATURATE_EN
    if (ove) ce = s ? 32'h80000000 : 32'h7FFFFFFF;
`endif
  endfunction

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] av,
                        input logic [31:0] bv);
    logic [31:0] ce;
    logic dze, ove;
    int lat;
    model(av, bv, ce, dze, ove);
    @(negedge clk);
    check("rdy_before", 64'(in_ready), 64'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("latency", 64'(lat), dze ? 64'd1 : 64'd48);
    check("c", 64'(c), 64'(ce));
    check("dz", 64'(div_by_zero), 64'(dze));
    check("ovf", 64'(overflow), 64'(ove));
    last_c = c;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_idle", 64'(in_ready), 64'd1);
    check("ov_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    check({tag, "_ov"}, 64'(out_valid), 64'd0);
    check({tag, "_c"}, 64'(c), 64'd0);
    check({tag, "_dz"}, 64'(div_by_zero), 64'd0);
    check({tag, "_of"}, 64'(overflow), 64'd0);
  endtask

  task automatic backpressure();
    logic [31:0] ce;
    logic dze, ove;
    int lat;
    model(32'hFFFF8000, 32'h00018000, ce, dze, ove);
    @(negedge clk);
    a = 32'hFFFF8000; b = 32'h00018000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_lat", 64'(lat), 64'd48);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2) == 0;
      a = 32'h00018000; b = 32'h00000000;
      @(posedge clk); #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_rdy", 64'(in_ready), 64'd0);
      check("bp_c", 64'(c), 64'(ce));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_noacc", 64'(out_valid), 64'd0);
    check("bp_noacc_rdy", 64'(in_ready), 64'd1);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    a = 32'h00018000; b = 32'h0000C000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_quiet", 64'(out_valid), 64'd0);
    run_op(32'h00018000, 32'h0000C000);
    check("midrst_fresh", 64'(last_c), 64'h00010000);
  endtask

  logic [31:0] ra, rb;

  initial begin
    #12;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h00018000, 32'h0000C000);
    check("t1_const", 64'(last_c), 64'h00010000);
    run_op(32'hFFFF8000, 32'h00020000);
    check("t2a_const", 64'(last_c), 64'hFFFFE000);
    run_op(32'hFFFF8000, 32'h00018000);
    check("t2b_const", 64'(last_c), 64'hFFFFD556);
    run_op(32'h00008000, 32'h00000000);
    run_op(32'h00000000, 32'h00000000);
    run_op(32'h80000000, 32'h00000000);
    run_op(32'h7FFFFFFF, 32'h00000001);
    run_op(32'h80000000, 32'h00008000);
    check("t4b_const", 64'(last_c), 64'h80000000);
    run_op(32'h80000000, 32'hFFFF8000);
    run_op(32'h00000000, 32'h12345678);
    run_op(32'hFFFFFFFF, 32'h7FFFFFFF);
    run_op(32'h00004000, 32'hFFFFFFFF);

    backpressure();
    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = rb & 32'h0000FFFF;
        1: ra = ra & 32'h0003FFFF;
        2: rb = (rb[0]) ? 32'h00008000 : 32'hFFFF8000;
        3: rb = 32'h0;
        default: ;
      endcase
      run_op(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
